brick_pixel_fetch: RTL and testbench

//  Upstream feeder for the brick sprite ROM. Holds the board map (brick type per grid cell),

---
 rtl/brick_pixel_fetch.sv | 110 +++++++++++
 tb/tb_brick_pixel_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_pixel_fetch.sv
// rtl/brick_pixel_fetch.sv - board map, pixel-to-sprite-ROM address stage and registered hit/colour output
module brick_pixel_fetch #(
  parameter int BRICK_W  = 32,
  parameter int BRICK_H  = 16,
  parameter int COLS     = 20,
  parameter int ROWS     = 15,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [18:0] rom_addr,
  output logic [3:0]  rom_type,
  input  logic [3:0]  rom_data,
  input  logic        map_we,
  input  logic [4:0]  map_col,
  input  logic [3:0]  map_row,
  input  logic [3:0]  map_type,
  input  logic        map_clear,
  output logic        out_valid,
  output logic        out_hit,
  output logic [3:0]  out_color,
  output logic [8:0]  brick_count
);

  localparam int LOG_W = $clog2(BRICK_W);
  localparam int LOG_H = $clog2(BRICK_H);
  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [10:0] GRID_W = 11'(COLS * BRICK_W);
  localparam logic [10:0] GRID_H = 11'(ROWS * BRICK_H);

  logic [3:0]       map_q [CELLS];
  logic [10:0]      rx, ry;
  logic             in_grid;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             wr_ok;
  logic [3:0]       old_type;
  logic             v1;
  logic             hit;

  // Bit 10 is the sign of the origin-relative coordinate.
  assign rx = {1'b0, draw_x} - 11'(ORIGIN_X);
  assign ry = {1'b0, draw_y} - 11'(ORIGIN_Y);
  assign in_grid = !rx[10] && !ry[10] && (rx < GRID_W) && (ry < GRID_H);

  always_comb begin
    rd_idx = '0;
    if (in_grid)
      rd_idx = IDX_W'(int'(ry[10:LOG_H]) * COLS + int'(rx[10:LOG_W]));
  end

  always_comb begin
    wr_ok  = (int'(map_col) < COLS) && (int'(map_row) < ROWS);
    wr_idx = '0;
    if (wr_ok)
      wr_idx = IDX_W'(int'(map_row) * COLS + int'(map_col));
    old_type = map_q[wr_idx];
  end

  // Map and occupancy count move together so the count always matches the map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) map_q[i] <= '0;
      brick_count <= '0;
    end else if (map_clear) begin
      for (int i = 0; i < CELLS; i++) map_q[i] <= '0;
      brick_count <= '0;
    end else if (map_we && wr_ok) begin
      map_q[wr_idx] <= map_type;
      if (old_type == 4'd0 && map_type != 4'd0)
        brick_count <= brick_count + 9'd1;
      else if (old_type != 4'd0 && map_type == 4'd0)
        brick_count <= brick_count - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      rom_addr <= '0;
      rom_type <= '0;
    end else begin
      v1 <= pix_valid;
      if (pix_valid) begin
        rom_addr <= {{(19 - LOG_H - LOG_W){1'b0}}, ry[LOG_H-1:0], rx[LOG_W-1:0]};
        rom_type <= in_grid ? map_q[rd_idx] : 4'd0;
      end
    end
  end

  // Sprite colour 0 is transparent; type 0 is an empty cell regardless of ROM content.
  assign hit = v1 && (rom_type != 4'd0) && (rom_data != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= v1;
      out_hit   <= hit;
      out_color <= hit ? rom_data : 4'd0;
    end
  end

endmodule

// File: tb/tb_brick_pixel_fetch.sv
// tb/tb_brick_pixel_fetch.sv - self-checking bench for brick_pixel_fetch (origin 0,0 and 64,32 instances)
module tb_brick_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [9:0]  draw_x, draw_y;
  logic        map_we, map_clear;
  logic [4:0]  map_col;
  logic [3:0]  map_row, map_type;

  logic [18:0] rom_addr_w [2];
  logic [3:0]  rom_type_w [2];
  logic [3:0]  rom_data_w [2];
  logic        out_valid_w [2];
  logic        out_hit_w [2];
  logic [3:0]  out_color_w [2];
  logic [8:0]  count_w [2];

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  // Stand-in sprite ROM: colour = (addr[3:0] + addr[7:4] + type) mod 16.
  function automatic int rom_fn(int a, int t);
    return ((a % 16) + ((a / 16) % 16) + t) % 16;
  endfunction

  assign rom_data_w[0] = 4'(rom_fn(int'(rom_addr_w[0]), int'(rom_type_w[0])));
  assign rom_data_w[1] = 4'(rom_fn(int'(rom_addr_w[1]), int'(rom_type_w[1])));

  brick_pixel_fetch u_a (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
    .rom_addr(rom_addr_w[0]), .rom_type(rom_type_w[0]), .rom_data(rom_data_w[0]),
    .map_we(map_we), .map_col(map_col), .map_row(map_row), .map_type(map_type),
    .map_clear(map_clear), .out_valid(out_valid_w[0]), .out_hit(out_hit_w[0]),
    .out_color(out_color_w[0]), .brick_count(count_w[0])
  );

  brick_pixel_fetch #(.ORIGIN_X(64), .ORIGIN_Y(32)) u_b (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
    .rom_addr(rom_addr_w[1]), .rom_type(rom_type_w[1]), .rom_data(rom_data_w[1]),
    .map_we(map_we), .map_col(map_col), .map_row(map_row), .map_type(map_type),
    .map_clear(map_clear), .out_valid(out_valid_w[1]), .out_hit(out_hit_w[1]),
    .out_color(out_color_w[1]), .brick_count(count_w[1])
  );

  // Model state: the board, the pixel latched for the ROM, and the pixel on the output.
  int mm [300];
  int mcount;
  int s1v [2], s1a [2], s1t [2];
  int ov [2], oh [2], oc [2];
  int orx [2] = '{0, 64};
  int ory [2] = '{0, 32};

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 300; i++) mm[i] = 0;
    mcount = 0;
    for (int k = 0; k < 2; k++) begin
      s1v[k] = 0; s1a[k] = 0; s1t[k] = 0;
      ov[k] = 0; oh[k] = 0; oc[k] = 0;
    end
  endtask

  task automatic lookup(int k, int x, int y, output int a, output int t);
    int rx, ry;
    rx = x - orx[k];
    ry = y - ory[k];
    t = 0;
    if (rx >= 0 && ry >= 0 && rx < 640 && ry < 240) t = mm[(ry / 16) * 20 + rx / 32];
    a = (((ry % 16) + 16) % 16) * 32 + (((rx % 32) + 32) % 32);
  endtask

  task automatic step(bit pv, int x, int y, bit we, int col, int row, int typ, bit clr);
    int ca [2], ct [2], rd;
    pix_valid = pv; draw_x = 10'(x); draw_y = 10'(y);
    map_we = we; map_col = 5'(col); map_row = 4'(row); map_type = 4'(typ); map_clear = clr;
    for (int k = 0; k < 2; k++) lookup(k, x, y, ca[k], ct[k]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rd = rom_fn(s1a[k], s1t[k]);
      ov[k] = s1v[k];
      oh[k] = (s1v[k] != 0 && s1t[k] != 0 && rd != 0) ? 1 : 0;
      oc[k] = oh[k] != 0 ? rd : 0;
      s1v[k] = pv;
      if (pv) begin s1a[k] = ca[k]; s1t[k] = ct[k]; end
    end
    if (clr) for (int i = 0; i < 300; i++) mm[i] = 0;
    else if (we && col < 20 && row < 15) mm[row * 20 + col] = typ;
    mcount = 0;
    for (int i = 0; i < 300; i++) if (mm[i] != 0) mcount++;
    @(negedge clk);
    #1;
    pix_valid = 0; map_we = 0; map_clear = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rom_addr[%0d]", k), int'(rom_addr_w[k]), s1a[k]);
        chk($sformatf("rom_type[%0d]", k), int'(rom_type_w[k]), s1t[k]);
        chk($sformatf("out_valid[%0d]", k), int'(out_valid_w[k]), ov[k]);
        chk($sformatf("out_hit[%0d]", k), int'(out_hit_w[k]), oh[k]);
        chk($sformatf("out_color[%0d]", k), int'(out_color_w[k]), oc[k]);
        chk($sformatf("brick_count[%0d]", k), int'(count_w[k]), mcount);
      end
    end
  end

  initial begin
    rst_n = 0; pix_valid = 0; draw_x = 0; draw_y = 0;
    map_we = 0; map_col = 0; map_row = 0; map_type = 0; map_clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    run_cmp = 1;
    chk("reset out_valid", int'(out_valid_w[0]), 0);
    chk("reset rom_addr", int'(rom_addr_w[0]), 0);
    chk("reset count", int'(count_w[0]), 0);
    idle(2);

    // Empty board, full line: valid two edges later, never a hit.
    for (int x = 0; x < 640; x++) begin
      step(1, x, 0, 0, 0, 0, 0, 0);
      if (x == 0) chk("line latency first edge", int'(out_valid_w[0]), 0);
      if (x == 1) chk("line latency second edge", int'(out_valid_w[0]), 1);
      if (out_hit_w[0] || out_hit_w[1]) chk("line no hit", 1, 0);
    end
    idle(2);

    // Single brick lookup; ROM gives transparent colour at addr 164.
    step(0, 0, 0, 1, 3, 2, 2, 0);
    step(1, 100, 37, 0, 0, 0, 0, 0);
    chk("px100_37 rom_addr", int'(rom_addr_w[0]), 164);
    chk("px100_37 rom_type", int'(rom_type_w[0]), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("px100_37 out_valid", int'(out_valid_w[0]), 1);
    chk("px100_37 out_hit", int'(out_hit_w[0]), 0);
    chk("px100_37 out_color", int'(out_color_w[0]), 0);
    step(0, 0, 0, 1, 3, 2, 0, 0);

    // Occupancy count.
    step(0, 0, 0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 2, 1, 1, 0);
    step(0, 0, 0, 1, 3, 1, 1, 0);
    chk("count three", int'(count_w[0]), 3);
    step(0, 0, 0, 1, 2, 1, 4, 0);
    chk("count overwrite", int'(count_w[0]), 3);
    step(0, 0, 0, 1, 3, 1, 0, 0);
    chk("count erase", int'(count_w[0]), 2);
    step(0, 0, 0, 1, 25, 1, 3, 0);
    chk("count out of range", int'(count_w[0]), 2);
    step(0, 0, 0, 1, 5, 5, 7, 1);
    chk("count clear", int'(count_w[0]), 0);
    step(1, 161, 82, 0, 0, 0, 0, 0);
    chk("clear beats write", int'(rom_type_w[0]), 0);
    step(1, 33, 17, 0, 0, 0, 0, 0);
    chk("clear wiped cell", int'(rom_type_w[0]), 0);

    // Write and lookup of the same cell in one cycle sees the old type.
    step(1, 0, 0, 1, 0, 0, 1, 0);
    chk("hazard old type", int'(rom_type_w[0]), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("hazard new type", int'(rom_type_w[0]), 1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("type1 px1 hit", int'(out_hit_w[0]), 1);
    chk("type1 px1 color", int'(out_color_w[0]), 2);

    // Offset grid on instance b.
    step(1, 63, 40, 0, 0, 0, 0, 0);
    chk("origin left of grid", int'(rom_type_w[1]), 0);
    step(1, 704, 40, 0, 0, 0, 0, 0);
    chk("origin right of grid", int'(rom_type_w[1]), 0);
    step(1, 64, 32, 0, 0, 0, 0, 0);
    chk("origin cell0 type", int'(rom_type_w[1]), 1);
    chk("origin cell0 addr", int'(rom_addr_w[1]), 0);
    idle(2);

    // Asynchronous reset with pixels in flight.
    step(0, 0, 0, 1, 4, 4, 9, 0);
    step(1, 128, 64, 0, 0, 0, 0, 0);
    step(1, 129, 64, 0, 0, 0, 0, 0);
    chk("pre-reset out_valid", int'(out_valid_w[0]), 1);
    pix_valid = 1; draw_x = 10'd130; draw_y = 10'd64;
    #1;
    rst_n = 0;
    model_reset();
    #1;
    chk("async reset out_valid", int'(out_valid_w[0]), 0);
    chk("async reset count", int'(count_w[0]), 0);
    pix_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post-reset out_valid", int'(out_valid_w[0]), 0);
    step(1, 128, 64, 0, 0, 0, 0, 0);
    chk("post-reset map empty", int'(rom_type_w[0]), 0);
    idle(3);

    run_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
